// File: rtl/uart_pkg.sv
// Shared UART/framing constants: byte width, frame header, parser state encoding.
// Latency: n/a (package).
// Backpressure: n/a (package).
package uart_pkg;

  localparam int BYTE_W = 8;

  // Default start-of-frame byte.
  localparam logic [BYTE_W-1:0] HDR_DEF = 8'hA5;

  // System clock and line rate shared with the UART receiver.
  localparam int CLK_HZ        = 25_000_000;
  localparam int BAUD          = 9600;
  localparam int BITS_PER_CHAR = 10;

  // One full character time in clk cycles, rounded up (26042 at 25 MHz / 9600).
  localparam int TIMEOUT_DEF = (CLK_HZ * BITS_PER_CHAR + BAUD - 1) / BAUD;

  // Frame parser states.
  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CSUM,
    SEND
  } state_t;

endpackage

// File: rtl/frame_buf.sv
// Single-frame payload store: DEPTH x byte register array, one write port, async read.
// Latency: write lands on the next clk edge; read is combinational from raddr.
// Backpressure: none; the parser only writes while filling and only reads while sending.
module frame_buf
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // Payload bytes are stored as they arrive; contents need no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_frame_parser.sv
// Frame parser: UART bytes -> [HDR][len][payload][csum] -> validated payload on valid/ready.
// Latency: first m_valid one cycle after the checksum byte strobe; then one byte per accepted handshake.
// Backpressure: m_data/m_last hold while m_ready=0; bytes arriving during SEND are dropped with an overrun pulse.
// Optional FRAME_TIMEOUT_EN: inter-byte gap timeout inside a frame (err_timeout); otherwise err_timeout is 0.
module rx_frame_parser
  import uart_pkg::*;
#(
  parameter int                MAX_LEN = 16,
  parameter logic [BYTE_W-1:0] HDR     = HDR_DEF
`ifdef FRAME_TIMEOUT_EN
  ,
  parameter int                TIMEOUT_CYCLES = TIMEOUT_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data_rx,
  input  logic              done_rx,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              frame_ok,
  output logic              err_len,
  output logic              err_csum,
  output logic              err_timeout,
  output logic              overrun
);

  // Buffer address width and a length width able to hold MAX_LEN itself.
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LW = $clog2(MAX_LEN + 1);

  state_t            state;
  logic [LW-1:0]     len;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     rd_idx;
  logic [BYTE_W-1:0] csum;
  logic              buf_we;
  logic [BYTE_W-1:0] buf_rdata;
  logic              tmo_hit;

  assign buf_we = done_rx && (state == PAYLOAD);

  frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_frame_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx),
    .wdata (data_rx),
    .raddr (rd_idx),
    .rdata (buf_rdata)
  );

  // rd_idx is a register and the buffer is frozen in SEND, so m_data is stable under stall.
  assign m_data = m_valid ? buf_rdata : '0;

`ifdef FRAME_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

  logic          in_frame;
  logic [GW-1:0] gap_cnt;

  assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CSUM);

  // A byte strobe in the same cycle as expiry wins: the frame is still alive.
  assign tmo_hit = in_frame && !done_rx && (gap_cnt == GW'(TIMEOUT_CYCLES - 1));

  // Count idle cycles since the last byte while a frame is open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (!in_frame || done_rx || tmo_hit) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Parser FSM: header/length/payload/checksum capture, then replay of the buffered payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len         <= '0;
      idx         <= '0;
      rd_idx      <= '0;
      csum        <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      frame_ok    <= 1'b0;
      err_len     <= 1'b0;
      err_csum    <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_ok    <= 1'b0;
      err_len     <= 1'b0;
      err_csum    <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;

      if (tmo_hit) begin
        err_timeout <= 1'b1;
        state       <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (done_rx && (data_rx == HDR)) begin
              state <= LEN;
            end
          end

          LEN: begin
            if (done_rx) begin
              if ((data_rx == '0) || (int'(data_rx) > MAX_LEN)) begin
                err_len <= 1'b1;
                state   <= IDLE;
              end else begin
                len   <= LW'(data_rx);
                csum  <= data_rx;
                idx   <= '0;
                state <= PAYLOAD;
              end
            end
          end

          PAYLOAD: begin
            if (done_rx) begin
              csum <= csum + data_rx;
              idx  <= idx + AW'(1);
              if ((LW'(idx) + LW'(1)) == len) begin
                state <= CSUM;
              end
            end
          end

          CSUM: begin
            if (done_rx) begin
              if (data_rx == csum) begin
                frame_ok <= 1'b1;
                rd_idx   <= '0;
                m_valid  <= 1'b1;
                m_last   <= (len == LW'(1));
                state    <= SEND;
              end else begin
                err_csum <= 1'b1;
                state    <= IDLE;
              end
            end
          end

          SEND: begin
            // Only one frame fits in the buffer; anything arriving now is lost.
            if (done_rx) begin
              overrun <= 1'b1;
            end
            if (m_ready) begin
              if (m_last) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                state   <= IDLE;
              end else begin
                rd_idx <= rd_idx + AW'(1);
                m_last <= ((LW'(rd_idx) + LW'(2)) == len);
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
